uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between N byte-producing requesters, for example ASCII senders, status reporters and echo logic.
- Grants requesters round-robin and latches the winning byte.
- Issues a one-cycle start pulse to the transmitter, then tracks the transmitter's busy level until the frame completes.
- Sits between the requesters and the uart instance, replacing the direct start/data wiring each sender uses today.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding and default parameters.
// Packet lock is built in when UART_ARB_PKT_LOCK_EN is defined.
package uart_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam int unsigned N_REQ_DEF        = 4;
    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer,
// or only the lock holder while a packet lock is held.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned  N_REQ = N_REQ_DEF,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]  i_ptr,
    input  logic             i_lock_en,
    input  logic [ID_W-1:0]  i_holder,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_any_valid
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_id  = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        if (i_lock_en) begin
            if (i_req_valid[i_holder]) begin
                o_grant[i_holder] = 1'b1;
                o_grant_id        = i_holder;
                o_any_valid       = 1'b1;
            end
        end else begin
            for (int off = 0; off < int'(N_REQ); off++) begin
                // Wrap by subtraction so non-power-of-two N_REQ works.
                w_sum = {1'b0, i_ptr} + (ID_W+1)'(off);
                if (w_sum >= (ID_W+1)'(N_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(N_REQ);
                end
                w_idx = w_sum[ID_W-1:0];
                if (!o_any_valid && i_req_valid[w_idx]) begin
                    o_grant[w_idx] = 1'b1;
                    o_grant_id     = w_idx;
                    o_any_valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on a requester until req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned  N_REQ        = N_REQ_DEF,
    parameter int unsigned  DATA_W       = DATA_W_DEF,
    parameter int unsigned  BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int unsigned ID_W         = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic                o_tx_start,
    output logic [DATA_W-1:0]   o_tx_data,
    input  logic                i_tx_busy,
    output logic [ID_W-1:0]     o_grant_id,
    output logic                o_active,
    output logic                o_err_timeout
);

    localparam int unsigned     CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]        r_state, w_state_nxt;
    logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_tx_start, w_start_nxt;
    logic              r_err, w_err_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic [ID_W-1:0]   r_grant_id;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_any_valid;
    logic              w_xfer;
    logic              w_timeout;
    logic              w_lock_en;
    logic [DATA_W-1:0] w_pick_data;

    function automatic logic [ID_W-1:0] f_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .i_lock_en   (w_lock_en),
        .i_holder    (r_grant_id),
        .o_grant     (w_grant),
        .o_grant_id  (w_pick_id),
        .o_any_valid (w_any_valid)
    );

    assign w_xfer    = (r_state == ST_IDLE) && w_any_valid;
    assign w_timeout = (r_state == ST_START) && !i_tx_busy && (r_cnt >= CNT_LAST);

    always_comb begin
        w_pick_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ID_W'(i) == w_pick_id) begin
                w_pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef UART_ARB_PKT_LOCK_EN
    logic r_lock, w_lock_nxt;

    // The holder is always the last granted requester, so r_grant_id doubles as it.
    assign w_lock_en = r_lock;

    always_comb begin
        w_lock_nxt = r_lock;
        if (w_xfer) begin
            w_lock_nxt = ~req_last[w_pick_id];
        end else if (w_timeout) begin
            w_lock_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_lock_en     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_start_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_START;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = f_inc(w_pick_id);
`ifdef UART_ARB_PKT_LOCK_EN
                    if (!req_last[w_pick_id]) begin
                        w_ptr_nxt = w_pick_id;
                    end
`endif
                end
            end
            ST_START: begin
                if (i_tx_busy) begin
                    w_state_nxt = ST_BUSY;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                    w_ptr_nxt   = f_inc(r_grant_id);
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!i_tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_start <= w_start_nxt;
            r_err      <= w_err_nxt;
            if (w_xfer) begin
                r_tx_data  <= w_pick_data;
                r_grant_id <= w_pick_id;
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE) ? w_grant : '0;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_grant_id;
    assign o_active      = (r_state != ST_IDLE);
    assign o_err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle vector table plus directed sequences.
// Lock-sequence expectations follow UART_ARB_PKT_LOCK_EN.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    logic [1:0]  o_grant_id;
    logic        o_active;
    logic        o_err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .i_tx_busy     (i_tx_busy),
        .o_grant_id    (o_grant_id),
        .o_active      (o_active),
        .o_err_timeout (o_err_timeout)
    );

    always @(negedge clk) begin
        if (o_tx_start === 1'b1) n_start++;
    end

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       busy;
        logic [3:0] exp_ready;
        logic       exp_start;
        logic [7:0] exp_data;
        logic [1:0] exp_gid;
        logic       exp_active;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change just after the active edge; outputs are sampled on the falling edge.
    task automatic drive(input logic [3:0] v, input logic b, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        i_tx_busy = b;
        rst       = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b1);
    endtask

    task automatic frame(input string tag, input logic [3:0] v, input int exp_id,
                         input logic [7:0] exp_data);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_id;
        drive(v, 1'b0, 1'b0);
        chk({tag, ".ready"}, 32'(req_ready), 32'(onehot));
        drive(v, 1'b0, 1'b0);
        chk({tag, ".start"}, 32'(o_tx_start), 32'd1);
        chk({tag, ".gid"}, 32'(o_grant_id), 32'(exp_id));
        chk({tag, ".data"}, 32'(o_tx_data), 32'(exp_data));
        chk({tag, ".ready_start"}, 32'(req_ready), 32'd0);
        drive(v, 1'b1, 1'b0);
        chk({tag, ".ready_start2"}, 32'(req_ready), 32'd0);
        drive(v, 1'b1, 1'b0);
        chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        drive(v, 1'b0, 1'b0);
        chk({tag, ".ready_busy_end"}, 32'(req_ready), 32'd0);
        chk({tag, ".active_busy_end"}, 32'(o_active), 32'd1);
    endtask

    initial begin
        int n0;
        int k1;
        int exp_id;
        int order[4];
        logic [3:0] v;
        logic [7:0] d;

        rst       = 1'b1;
        req_valid = '0;
        i_tx_busy = 1'b0;
        req_last  = 4'b1111;
        req_data  = {8'h33, 8'h41, 8'h22, 8'h55};

        //           rst   valid    busy  ready    st    data   gid   act   err
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'h41, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h55, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 8'h55, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].busy, vecs[i].rst);
            chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d.start", i), 32'(o_tx_start), 32'(vecs[i].exp_start));
            chk($sformatf("vec%0d.data", i), 32'(o_tx_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d.gid", i), 32'(o_grant_id), 32'(vecs[i].exp_gid));
            chk($sformatf("vec%0d.active", i), 32'(o_active), 32'(vecs[i].exp_active));
            chk($sformatf("vec%0d.err", i), 32'(o_err_timeout), 32'(vecs[i].exp_err));
        end

        // Single requester, 100-cycle frame.
        do_reset();
        n0 = n_start;
        drive(4'b0100, 1'b0, 1'b0);
        chk("single.ready", 32'(req_ready), 32'h4);
        drive(4'b0000, 1'b0, 1'b0);
        chk("single.start", 32'(o_tx_start), 32'd1);
        chk("single.data", 32'(o_tx_data), 32'h41);
        chk("single.gid", 32'(o_grant_id), 32'd2);
        for (int j = 0; j < 100; j++) begin
            drive(4'b0000, 1'b1, 1'b0);
            if (o_active !== 1'b1 || o_tx_data !== 8'h41) begin
                chk($sformatf("single.hold%0d", j), 32'({o_active, o_tx_data}), 32'h141);
            end
        end
        drive(4'b0000, 1'b0, 1'b0);
        chk("single.active_busy_fall", 32'(o_active), 32'd1);
        drive(4'b0000, 1'b0, 1'b0);
        chk("single.active_after", 32'(o_active), 32'd0);
        chk("single.start_count", 32'(n_start - n0), 32'd1);

        // Round-robin with all requesters valid.
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 5; k++) begin
            d = 8'hA0 + 8'(k % 4);
            frame($sformatf("rr%0d", k), 4'b1111, k % 4, d);
        end

        // Busy never rises: timeout, then the next requester wins.
        do_reset();
        req_last = 4'b1101;
        req_data = {8'h33, 8'h41, 8'h22, 8'h55};
        drive(4'b0010, 1'b0, 1'b0);
        chk("to.ready", 32'(req_ready), 32'h2);
        drive(4'b0000, 1'b0, 1'b0);
        chk("to.start", 32'(o_tx_start), 32'd1);
        chk("to.gid", 32'(o_grant_id), 32'd1);
        for (int j = 1; j < 16; j++) begin
            drive(4'b0000, 1'b0, 1'b0);
            chk($sformatf("to.no_err%0d", j), 32'({o_err_timeout, o_active}), 32'h1);
        end
        drive(4'b1111, 1'b0, 1'b0);
        chk("to.err", 32'(o_err_timeout), 32'd1);
        chk("to.idle", 32'(o_active), 32'd0);
        chk("to.next_ready", 32'(req_ready), 32'h4);
        drive(4'b1111, 1'b0, 1'b0);
        chk("to.err_pulse", 32'(o_err_timeout), 32'd0);
        chk("to.next_start", 32'(o_tx_start), 32'd1);
        chk("to.next_gid", 32'(o_grant_id), 32'd2);
        req_last = 4'b1111;

        // Reset during BUSY.
        do_reset();
        req_data = {8'h33, 8'h41, 8'h22, 8'h77};
        drive(4'b0001, 1'b0, 1'b0);
        chk("rstmid.ready", 32'(req_ready), 32'h1);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        chk("rstmid.busy_active", 32'(o_active), 32'd1);
        drive(4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 1'b1, 1'b0);
        chk("rstmid.start", 32'(o_tx_start), 32'd0);
        chk("rstmid.data", 32'(o_tx_data), 32'd0);
        chk("rstmid.gid", 32'(o_grant_id), 32'd0);
        chk("rstmid.active", 32'(o_active), 32'd0);
        chk("rstmid.err", 32'(o_err_timeout), 32'd0);
        chk("rstmid.ready0", 32'(req_ready), 32'd0);
        drive(4'b1111, 1'b0, 1'b0);
        chk("rstmid.ptr", 32'(req_ready), 32'h1);

        // Requester 1 sends a 3-byte packet while requester 0 stays valid.
`ifdef UART_ARB_PKT_LOCK_EN
        order = '{1, 1, 1, 0};
`else
        order = '{1, 0, 1, 0};
`endif
        do_reset();
        req_last = 4'b1111;
        req_data = {8'h33, 8'h22, 8'h10, 8'h50};
        frame("lock.prime", 4'b0001, 0, 8'h50);
        k1 = 0;
        for (int i = 0; i < 4; i++) begin
            v = (k1 < 3) ? 4'b0011 : 4'b0001;
            req_last[1] = (k1 == 2);
            req_data[15:8] = 8'h10 + 8'(k1);
            exp_id = order[i];
            d = (exp_id == 1) ? 8'h10 + 8'(k1) : 8'h50;
            frame($sformatf("lock%0d", i), v, exp_id, d);
            if (exp_id == 1) k1++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
